// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM for the multicycle shared-ALU/shared-memory MIPS datapath
// Inputs : clk, reset (async, active-high), op/funct from the instruction register, zero from the ALU
// Outputs: pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc,
//          alucontrol, illegal (DECODE pulse on unsupported op), state (debug)
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, RTYPEEX = 4'd6, RTYPEWB = 4'd7, BEQEX = 4'd8, BNEEX = 4'd9,
    ADDIEX = 4'd10, ADDIWB = 4'd11, JEX = 4'd12, JALEX = 4'd13, JREX = 4'd14
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_J = 6'b000010,
    OP_JAL = 6'b000011, FN_JR = 6'b001000;
  state_t state_q, state_d;
  logic pcwrite, branch, bne, mw, irw, rw;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d = FETCH;
    pcwrite = 1'b0;
    branch = 1'b0;
    bne = 1'b0;
    iord = 1'b0;
    mw = 1'b0;
    irw = 1'b0;
    rw = 1'b0;
    regdst = 2'b00;
    memtoreg = 2'b00;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    alucontrol = 3'b010;
    illegal = 1'b0;
    case (state_q)
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R: state_d = (funct == FN_JR) ? JREX : RTYPEEX;
          OP_BEQ: state_d = BEQEX;
          OP_BNE: state_d = BNEEX;
          OP_ADDI: state_d = ADDIEX;
          OP_J: state_d = JEX;
          OP_JAL: state_d = JALEX;
          default: illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        rw = 1'b1;
        memtoreg = 2'b01;
      end
      MEMWR: begin
        iord = 1'b1;
        mw = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        alucontrol = (funct == 6'b100010) ? 3'b110 :
                     (funct == 6'b100100) ? 3'b000 :
                     (funct == 6'b100101) ? 3'b001 :
                     (funct == 6'b101010) ? 3'b111 : 3'b010;
        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        rw = 1'b1;
        regdst = 2'b01;
      end
      BEQEX, BNEEX: begin
        alusrca = 1'b1;
        alucontrol = 3'b110;
        pcsrc = 2'b01;
        branch = (state_q == BEQEX);
        bne = (state_q == BNEEX);
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: rw = 1'b1;
      JEX: begin
        pcsrc = 2'b10;
        pcwrite = 1'b1;
      end
      JALEX: begin
        // PC already holds PC+4 from FETCH, so it is the link value written on the jump edge
        pcsrc = 2'b10;
        pcwrite = 1'b1;
        rw = 1'b1;
        regdst = 2'b10;
        memtoreg = 2'b10;
      end
      JREX: begin
        pcsrc = 2'b11;
        pcwrite = 1'b1;
      end
      default: begin
        irw = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
        state_d = DECODE;
      end
    endcase
  end
  // write enables are held off while reset is high even though state already reads FETCH
  assign pcen = ~reset & (pcwrite | (branch & zero) | (bne & ~zero));
  assign irwrite = ~reset & irw;
  assign regwrite = ~reset & rw;
  assign memwrite = ~reset & mw;
  assign state = state_q;
endmodule
